// File: rtl/lvt_multiport_ram.sv
// Multi-ported RAM: NUM_WR x NUM_RD banks, with a live value table selecting each address's latest writer.
// Optional same-cycle write-to-read forwarding is enabled with `define LVT_BYPASS_EN.
module lvt_multiport_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WR     = 4,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_RD-1:0]            rd_en_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_valid_o,
  output logic                         init_busy_o,
  output logic                         wr_collision_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LVT_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    init_busy_q;
  logic                    run;

  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (&cnt_q) begin
            state_q     <= ST_RUN;
            init_busy_q <= 1'b0;
          end
        end
        ST_RUN: ;
      endcase
    end
  end

  // Later loop iterations override earlier ones, so the highest port index owns a contested entry.
  logic [LVT_W-1:0] lvt_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) lvt_q[i] <= '0;
    end else if (!run) begin
      lvt_q[cnt_q] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en_i[p]) lvt_q[wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <= LVT_W'(p);
    end
  end

  logic [LVT_W-1:0]  lvt_rd_q [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_RD; r++) lvt_rd_q[r] <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_valid_q <= run ? rd_en_i : '0;
      for (int r = 0; r < NUM_RD; r++)
        if (run && rd_en_i[r]) lvt_rd_q[r] <= lvt_q[rd_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  logic [DATA_WIDTH-1:0] bank_rd [NUM_WR][NUM_RD];

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    for (genvar gj = 0; gj < NUM_RD; gj++) begin : g_rd
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;

      // Contents are cleared only by the sweep, never by rst.
      always_ff @(posedge clk) begin
        if (!run)
          mem[cnt_q] <= '0;
        else if (wr_en_i[gi])
          mem[wr_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          rd_q <= '0;
        else if (run && rd_en_i[gj])
          rd_q <= mem[rd_addr_i[gj*ADDR_WIDTH +: ADDR_WIDTH]];
      end

      assign bank_rd[gi][gj] = rd_q;
    end
  end

`ifdef LVT_BYPASS_EN
  logic [NUM_RD-1:0]     fwd_hit_d, fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_d [NUM_RD];
  logic [DATA_WIDTH-1:0] fwd_data_q [NUM_RD];

  always_comb begin
    fwd_hit_d = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      fwd_data_d[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en_i[p] &&
            wr_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
          fwd_hit_d[r]  = 1'b1;
          fwd_data_d[r] = wr_data_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_q <= '0;
      for (int r = 0; r < NUM_RD; r++) fwd_data_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_RD; r++) begin
        if (run && rd_en_i[r]) begin
          fwd_hit_q[r]  <= fwd_hit_d[r];
          fwd_data_q[r] <= fwd_data_d[r];
        end
      end
    end
  end
`endif

  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
`ifdef LVT_BYPASS_EN
      if (fwd_hit_q[r])
        rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = fwd_data_q[r];
      else
`endif
        rd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = bank_rd[lvt_rd_q[r]][r];
    end
  end

  logic wr_collision_d, wr_collision_q;

  always_comb begin
    wr_collision_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_en_i[i] && wr_en_i[j] &&
            wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH])
          wr_collision_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_collision_q <= 1'b0;
    else     wr_collision_q <= run && wr_collision_d;
  end

  assign rd_valid_o     = rd_valid_q;
  assign init_busy_o    = init_busy_q;
  assign wr_collision_o = wr_collision_q;

endmodule
